// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the 1x3 router datapath.
// Header byte layout is {len, addr} with addr in the low HDR_ADDR_W bits.
package router_pkg;

  localparam int ROUTER_DATA_W = 8;
  localparam int HDR_ADDR_W    = 2;
  localparam int HDR_LEN_LSB   = 2;

  typedef logic [ROUTER_DATA_W-HDR_LEN_LSB-1:0] router_len_t;

endpackage

// File: rtl/router_fifo_pkt_tracker.sv
// router_fifo_pkt_tracker: read-side packet boundary tracking for the FIFO.
// Parity accumulator exists only when ROUTER_FIFO_PARITY_EN is defined.
module router_fifo_pkt_tracker
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              i_rd_fire,
  input  logic              i_tag,
  input  logic [DATA_W-1:0] i_rd_byte,
  output logic              o_pkt_done,
  output logic              o_parity_err
);

  localparam int LEN_W = DATA_W - HDR_LEN_LSB;
  localparam int REM_W = LEN_W + 1;

  logic [REM_W-1:0] r_rem;
  logic             r_pkt_done;
  logic [LEN_W-1:0] w_len;
  logic             w_last;
  logic             w_busy;

  assign w_len  = i_rd_byte[DATA_W-1:HDR_LEN_LSB];
  assign w_last = (r_rem == REM_W'(1));
  assign w_busy = (r_rem != '0);

  // A header always restarts tracking, even over an unfinished packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rem      <= '0;
      r_pkt_done <= 1'b0;
    end else if (soft_reset) begin
      r_rem      <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (i_rd_fire) begin
        if (i_tag) begin
          r_rem <= {1'b0, w_len} + REM_W'(1);
        end else if (w_last) begin
          r_rem      <= '0;
          r_pkt_done <= 1'b1;
        end else if (w_busy) begin
          r_rem <= r_rem - REM_W'(1);
        end
      end
    end
  end

  assign o_pkt_done = r_pkt_done;

`ifdef ROUTER_FIFO_PARITY_EN
  logic [DATA_W-1:0] r_acc;
  logic              r_parity_err;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_acc        <= '0;
      r_parity_err <= 1'b0;
    end else if (soft_reset) begin
      r_acc        <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (i_rd_fire) begin
        if (i_tag) begin
          r_acc <= i_rd_byte;
        end else if (w_last) begin
          r_parity_err <= (r_acc != i_rd_byte);
        end else if (w_busy) begin
          r_acc <= r_acc ^ i_rd_byte;
        end
      end
    end
  end

  assign o_parity_err = r_parity_err;
`else
  logic w_unused_addr;

  assign w_unused_addr = ^i_rd_byte[HDR_ADDR_W-1:0];
  assign o_parity_err  = 1'b0;
`endif

endmodule

// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware channel FIFO, one instance per router output.
// Define ROUTER_FIFO_PARITY_EN to build the read-side parity check.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_W    = ROUTER_DATA_W,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              pkt_done,
  output logic              parity_err
);

  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C   = (ADDR_W+1)'(DEPTH - AF_MARGIN);

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W:0]   w_head;

  assign full        = (r_count == FULL_C);
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= AF_C);
  assign count       = r_count;
  assign data_out    = r_data_out;

  assign w_wr   = write_enb && !full;
  assign w_rd   = read_enb && !empty;
  assign w_head = r_mem[r_rptr];

  // Flush leaves stored bytes in place; only the pointers forget them.
  always_ff @(posedge clock) begin
    if (w_wr && !soft_reset)
      r_mem[r_wptr] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else if (soft_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + ADDR_W'(1);
      if (w_rd) begin
        r_rptr     <= r_rptr + ADDR_W'(1);
        r_data_out <= w_head[DATA_W-1:0];
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  router_fifo_pkt_tracker #(
    .DATA_W(DATA_W)
  ) u_tracker (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .i_rd_fire   (w_rd),
    .i_tag       (w_head[DATA_W]),
    .i_rd_byte   (w_head[DATA_W-1:0]),
    .o_pkt_done  (pkt_done),
    .o_parity_err(parity_err)
  );

endmodule
